uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter DATA_BITS, default 8: character width, matching the UART transmitter.
REQ-003 SHALL have parameter START_TIMEOUT, default 1024: maximum cycles to wait for uart_tx_active_i to rise after a launch.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port req_vld_i, input, NUM_REQ: bit k set means requester k offers a character.
REQ-007 SHALL have port req_data_i, input, NUM_REQ*DATA_BITS: character of requester k in bits [k*DATA_BITS +: DATA_BITS].
REQ-008 SHALL have port req_rdy_o, output, NUM_REQ: one-hot or zero; a transfer occurs when req_vld_i[k] & req_rdy_o[k].
REQ-009 SHALL have port uart_tx_data_o, output, DATA_BITS: character to the UART transmitter.
REQ-010 SHALL have port uart_tx_data_vld_o, output, 1: one-cycle launch strobe to the transmitter.
REQ-011 SHALL have port uart_we_o, output, 1: write enable to the UART, asserted only together with uart_tx_data_vld_o.
REQ-012 SHALL have port uart_tx_active_i, input, 1: transmitter busy flag.
REQ-013 SHALL have port grant_id_o, output, clog2(NUM_REQ): index of the requester currently owning the transmitter.
REQ-014 SHALL have port busy_o, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port timeout_err_o, output, 1: one-cycle pulse on start timeout.

Function
REQ-016 SHALL implement FSM states IDLE, LAUNCH, WAIT_START, WAIT_DONE.
REQ-017 IDLE SHALL, when any req_vld_i bit is set and uart_tx_active_i=0, select winner k by round-robin starting at last_grant+1 (mod NUM_REQ).
REQ-017a IDLE SHALL then assert req_rdy_o[k] combinationally in that cycle, capture req_data_i slice k and k, set last_grant=k, and go to LAUNCH.
REQ-018 req_rdy_o SHALL be all-zero in every state except IDLE, and in IDLE whenever uart_tx_active_i=1 or no request is pending.
REQ-019 LAUNCH SHALL assert uart_tx_data_vld_o=1 and uart_we_o=1 for exactly one cycle, then go to WAIT_START; latency from accepting handshake to strobe is exactly 1 cycle.
REQ-020 uart_tx_data_o SHALL hold the captured character from LAUNCH until the next capture; it is zero only after reset.
REQ-021 WAIT_START SHALL go to WAIT_DONE on the cycle uart_tx_active_i=1; otherwise it SHALL increment a wait counter (cleared on entry).
REQ-021a When the counter reaches START_TIMEOUT-1 without uart_tx_active_i, WAIT_START SHALL pulse timeout_err_o for one cycle and return to IDLE; the character is dropped.
REQ-022 WAIT_DONE SHALL return to IDLE on the first cycle uart_tx_active_i=0; there is no timeout in WAIT_DONE.
REQ-023 A requester dropping req_vld_i before being granted SHALL cause no transfer; data is sampled only in the handshake cycle.
REQ-024 A single persistent requester SHALL be re-granted on the first IDLE cycle after its previous character completes.
REQ-024a With all requesters persistent, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0.
REQ-025 Changes on req_vld_i/req_data_i outside IDLE SHALL have no effect on the transfer in progress.

Reset
REQ-026 On rst_ni=0, asynchronously: state=IDLE, req_rdy_o=0, uart_tx_data_o=0, uart_tx_data_vld_o=0, uart_we_o=0, grant_id_o=0, busy_o=0, timeout_err_o=0, wait counter=0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-027 Reset asserted mid-transfer SHALL abandon it with no timeout pulse; after release the first grant again goes to the lowest pending index per REQ-026.

Verification
REQ-028 Single request: req_vld_i=4'b0100, data 0x5A -> req_rdy_o=4'b0100 same cycle, uart_tx_data_vld_o=1 with 0x5A next cycle, grant_id_o=2, busy_o until tx_active falls.
REQ-029 All four persistent requests, model returns tx_active 3 cycles after strobe for 20 cycles -> grant order 0,1,2,3,0,1; each character matches its requester's data.
REQ-030 Model never raises tx_active, START_TIMEOUT=16 -> timeout_err_o pulses exactly 16 cycles after LAUNCH, FSM in IDLE, next requester granted.
REQ-031 uart_tx_active_i held 1 at reset release with requests pending -> req_rdy_o stays 0 until tx_active drops, then grant to requester 0.
REQ-032 rst_ni pulsed low during WAIT_DONE -> all outputs zero immediately; after release, pending requests 1 and 3 -> requester 1 granted first.
REQ-033 Requester 0 pulses req_vld_i for one cycle while FSM is in WAIT_DONE -> no grant to requester 0 afterwards, no extra strobe.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one UART transmitter among
// NUM_REQ requesters. A requester is accepted only in IDLE while the
// transmitter is quiet. Its character is launched with a one-cycle strobe.
// The arbiter then waits for the transmitter to go busy and back to idle.
// If the transmitter never starts, the arbiter gives up after a bounded wait.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), async active-low reset
//   req_vld_i[k]         requester k offers a character
//   req_data_i           character of requester k at [k*DATA_BITS +: DATA_BITS]
//   req_rdy_o            one-hot accept (combinational, IDLE only)
//   uart_tx_data_o       character presented to the transmitter
//   uart_tx_data_vld_o   one-cycle launch strobe
//   uart_we_o            write enable, high only with the strobe
//   uart_tx_active_i     transmitter busy flag
//   grant_id_o           index of the requester owning the transmitter
//   busy_o               arbiter not in IDLE
//   timeout_err_o        one-cycle pulse when the transmitter never started
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for a request while the transmitter is idle
// S_LAUNCH     | strobe asserted for the captured character
// S_WAIT_START | waiting for uart_tx_active_i to rise, bounded by a counter
// S_WAIT_DONE  | transmitter busy, waiting for it to fall
module uart_tx_arb #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = 8,
    parameter int START_TIMEOUT = 1024,
    localparam int GW           = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_vld_i,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]             req_rdy_o,
    output logic [DATA_BITS-1:0]           uart_tx_data_o,
    output logic                           uart_tx_data_vld_o,
    output logic                           uart_we_o,
    input  logic                           uart_tx_active_i,
    output logic [GW-1:0]                  grant_id_o,
    output logic                           busy_o,
    output logic                           timeout_err_o
);

    localparam int GW1 = GW + 1;
    localparam int CW  = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t                 state;
    logic [GW-1:0]          last_grant;
    logic [CW-1:0]          wait_cnt;

    logic [GW:0]            cand;
    logic [GW-1:0]          win_idx;
    logic                   win_found;
    logic [DATA_BITS-1:0]   win_data;
    logic                   grant_ok;

    // Round-robin search from last_grant+1. Walking the offsets from the
    // farthest to the nearest lets the nearest pending requester win.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, last_grant} + GW1'(i);
            if (cand >= GW1'(NUM_REQ)) begin
                cand = cand - GW1'(NUM_REQ);
            end
            if (req_vld_i[cand[GW-1:0]]) begin
                win_idx   = cand[GW-1:0];
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = req_data_i[win_idx*DATA_BITS +: DATA_BITS];
    end

    // rst_ni is included so that the combinational accept is also zero while reset is held.
    assign grant_ok = rst_ni && (state == S_IDLE) && !uart_tx_active_i && win_found;

    always_comb begin
        req_rdy_o = '0;
        if (grant_ok) begin
            req_rdy_o[win_idx] = 1'b1;
        end
    end

    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= S_IDLE;
            last_grant         <= GW'(NUM_REQ - 1);
            wait_cnt           <= '0;
            uart_tx_data_o     <= '0;
            uart_tx_data_vld_o <= 1'b0;
            uart_we_o          <= 1'b0;
            grant_id_o         <= '0;
            timeout_err_o      <= 1'b0;
        end else begin
            uart_tx_data_vld_o <= 1'b0;
            uart_we_o          <= 1'b0;
            timeout_err_o      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        uart_tx_data_o     <= win_data;
                        grant_id_o         <= win_idx;
                        last_grant         <= win_idx;
                        uart_tx_data_vld_o <= 1'b1;
                        uart_we_o          <= 1'b1;
                        state              <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (uart_tx_active_i) begin
                        state <= S_WAIT_DONE;
                    end else if (wait_cnt == CW'(START_TIMEOUT - 2)) begin
                        // Counter would now reach START_TIMEOUT-1. The
                        // registered pulse therefore lands START_TIMEOUT
                        // cycles after the strobe.
                        timeout_err_o <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!uart_tx_active_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb (NUM_REQ=4, DATA_BITS=8, START_TIMEOUT=16).
// Each accepted request pushes its expected {grant id, character} into a
// queue. A monitor pops and compares on every launch strobe. Directed
// checks cover the accept timing, reset, timeout, and the blocking cases.
module tb_uart_tx_arb;

    localparam int NR = 4;
    localparam int DB = 8;
    localparam int TO = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [NR-1:0]   req_vld_i = '0;
    logic [NR*DB-1:0] req_data_i = '0;
    logic [NR-1:0]   req_rdy_o;
    logic [DB-1:0]   uart_tx_data_o;
    logic            uart_tx_data_vld_o;
    logic            uart_we_o;
    logic            uart_tx_active_i;
    logic [1:0]      grant_id_o;
    logic            busy_o;
    logic            timeout_err_o;

    logic            tx_force = 1'b0;
    logic            model_act = 1'b0;
    logic            model_en = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int strobe_cnt = 0;
    logic [9:0] exp_q[$];

    assign uart_tx_active_i = tx_force | model_act;

    always #5 clk_i = ~clk_i;

    uart_tx_arb #(.NUM_REQ(NR), .DATA_BITS(DB), .START_TIMEOUT(TO)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_vld_i          (req_vld_i),
        .req_data_i         (req_data_i),
        .req_rdy_o          (req_rdy_o),
        .uart_tx_data_o     (uart_tx_data_o),
        .uart_tx_data_vld_o (uart_tx_data_vld_o),
        .uart_we_o          (uart_we_o),
        .uart_tx_active_i   (uart_tx_active_i),
        .grant_id_o         (grant_id_o),
        .busy_o             (busy_o),
        .timeout_err_o      (timeout_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model: goes busy 3 cycles after a strobe and stays busy for 20 cycles.
    initial begin
        int dly;
        int act;
        dly = 0;
        act = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                dly = 0;
                act = 0;
                model_act = 1'b0;
            end else begin
                if (act > 0) begin
                    act--;
                    if (act == 0) model_act = 1'b0;
                end else if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        model_act = 1'b1;
                        act = 20;
                    end
                end
                if (uart_tx_data_vld_o && model_en) dly = 3;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk_i);
            if (uart_tx_data_vld_o) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {22'd0, grant_id_o, uart_tx_data_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_id_data", {22'd0, grant_id_o, uart_tx_data_o}, {22'd0, e});
                    check("strobe_we", {31'd0, uart_we_o}, 32'd1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (busy_o && n < max);
        if (busy_o) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_strobe(input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!uart_tx_data_vld_o && n < max);
        if (!uart_tx_data_vld_o) check("wait_strobe_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_active(input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!uart_tx_active_i && n < max);
        if (!uart_tx_active_i) check("wait_active_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},   {28'd0, req_rdy_o}, 32'd0);
        check({tag, "_data"},  {24'd0, uart_tx_data_o}, 32'd0);
        check({tag, "_vld"},   {31'd0, uart_tx_data_vld_o}, 32'd0);
        check({tag, "_we"},    {31'd0, uart_we_o}, 32'd0);
        check({tag, "_gid"},   {30'd0, grant_id_o}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
        check({tag, "_tmo"},   {31'd0, timeout_err_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        // Reset state
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single request from requester 2
        step();
        req_data_i[16 +: 8] = 8'h5A;
        req_vld_i = 4'b0100;
        exp_q.push_back({2'd2, 8'h5A});
        @(negedge clk_i);
        check("single_rdy", {28'd0, req_rdy_o}, 32'h4);
        step();
        req_vld_i = '0;
        req_data_i[16 +: 8] = 8'hFF;          // must not disturb the transfer
        @(negedge clk_i);
        check("single_strobe_latency", {31'd0, uart_tx_data_vld_o}, 32'd1);
        check("single_gid", {30'd0, grant_id_o}, 32'd2);
        check("single_busy", {31'd0, busy_o}, 32'd1);
        wait_idle(100);
        check("single_data_held", {24'd0, uart_tx_data_o}, 32'h5A);

        // All four persistent after a fresh reset: 0,1,2,3,0,1
        step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        req_data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        exp_q.push_back({2'd0, 8'hA0});
        exp_q.push_back({2'd1, 8'hA1});
        exp_q.push_back({2'd2, 8'hA2});
        exp_q.push_back({2'd3, 8'hA3});
        exp_q.push_back({2'd0, 8'hA0});
        exp_q.push_back({2'd1, 8'hA1});
        start = strobe_cnt;
        req_vld_i = 4'hF;
        for (int n = 0; n < 600 && strobe_cnt < start + 6; n++) @(negedge clk_i);
        step();
        req_vld_i = '0;
        check("rr_strobe_count", strobe_cnt - start, 32'd6);
        wait_idle(100);

        // Start timeout: last grant was 1, so 0 wins, then 1 after the timeout
        model_en = 1'b0;
        step();
        req_data_i = {8'h00, 8'h00, 8'h22, 8'h11};
        req_vld_i = 4'b0011;
        exp_q.push_back({2'd0, 8'h11});
        exp_q.push_back({2'd1, 8'h22});
        @(negedge clk_i);
        check("tmo_rdy0", {28'd0, req_rdy_o}, 32'h1);
        wait_strobe(5);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk_i);
            check($sformatf("tmo_pulse_k%0d", k), {31'd0, timeout_err_o}, (k == TO) ? 32'd1 : 32'd0);
        end
        check("tmo_idle", {31'd0, busy_o}, 32'd0);
        check("tmo_next_rdy1", {28'd0, req_rdy_o}, 32'h2);
        step();
        req_vld_i = '0;
        wait_idle(60);
        model_en = 1'b1;

        // tx_active held high across reset release
        step();
        rst_ni = 1'b0;
        tx_force = 1'b1;
        req_data_i = {8'h00, 8'h44, 8'h00, 8'h33};
        req_vld_i = 4'b0101;
        step();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("active_block_rdy", {28'd0, req_rdy_o}, 32'd0);
        end
        step();
        tx_force = 1'b0;
        exp_q.push_back({2'd0, 8'h33});
        #1;
        check("active_release_rdy0", {28'd0, req_rdy_o}, 32'h1);
        step();
        req_vld_i = '0;
        wait_idle(100);

        // Reset during WAIT_DONE; then 1 and 3 pending gives requester 1
        step();
        req_data_i = {8'h00, 8'h77, 8'h00, 8'h00};
        req_vld_i = 4'b0100;
        exp_q.push_back({2'd2, 8'h77});
        step();
        req_vld_i = '0;
        wait_active(20);
        step();
        step();
        check("wd_busy_before_rst", {31'd0, busy_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        req_data_i = {8'h99, 8'h00, 8'h88, 8'h00};
        req_vld_i = 4'b1010;
        #1;
        check_all_zero("midrst");
        @(posedge clk_i);
        exp_q.push_back({2'd1, 8'h88});
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("midrst_first_rdy1", {28'd0, req_rdy_o}, 32'h2);
        step();
        req_vld_i = '0;
        wait_idle(100);

        // Requester 0 pulses only during WAIT_DONE: no grant to it
        step();
        req_data_i = {8'h00, 8'h5C, 8'h00, 8'hEE};
        req_vld_i = 4'b0100;
        exp_q.push_back({2'd2, 8'h5C});
        step();
        req_vld_i = '0;
        wait_active(20);
        step();
        step();
        req_vld_i = 4'b0001;
        step();
        req_vld_i = '0;
        start = strobe_cnt;
        wait_idle(100);
        repeat (30) @(negedge clk_i);
        check("pulse_no_extra_strobe", strobe_cnt - start, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
